apb_reg_slave: RTL and testbench

//  APB3 completer (register-file target) hung off one APB master port of the ICB->APB bridge; one instance per APB channel.

---
 rtl/apb_slave_pkg.sv | 31 +++
 rtl/apb_wait_gen.sv | 35 +++
 rtl/apb_reg_slave.sv | 149 ++++++++++++++
 tb/tb_apb_reg_slave.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and address decode for APB register targets.
package apb_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int unsigned APB_WORD_BYTES = 4;
  localparam int unsigned WAIT_CNT_W     = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } apb_dec_t;

  // Word index plus error flag; the top word of the file is read-only.
  function automatic apb_dec_t apb_decode(input logic [31:0]  paddr,
                                          input logic [31:0]  base,
                                          input int unsigned  nregs,
                                          input logic         pwrite);
    apb_dec_t    d;
    logic [31:0] off;
    off   = paddr - base;
    d.idx = off >> $clog2(APB_WORD_BYTES);
    d.err = (paddr[1:0] != 2'b00) | (paddr < base) | (d.idx >= nregs) |
            (pwrite & (d.idx == nregs - 1));
    return d;
  endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// Loadable down-counter that paces PREADY for APB targets.
module apb_wait_gen
  import apb_slave_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  dec_i,
  input  logic [WAIT_CNT_W-1:0] n_i,
  output logic                  done_o
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = n_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last wait cycle: the next access cycle carries PREADY.
  assign done_o = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register-file completer with programmable wait states and a read-only
// wrapping count of committed writes in the top word.
module apb_reg_slave
  import apb_slave_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  state_e                state_q, state_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [31:0]           idx_q;
  logic                  err_q, write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] wcnt_q;

  apb_dec_t              dec_live;
  logic                  accept, commit, wt_load, wt_dec, wt_done;
  logic [31:0]           ld_idx;
  logic                  ld_err, ld_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] view_w [NUM_REGS];

  assign dec_live = apb_decode(32'(paddr), 32'(BASE_ADDR), NUM_REGS, pwrite);

  apb_wait_gen u_wait (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (wt_load),
    .dec_i  (wt_dec),
    .n_i    (WAIT_CNT_W'(WAIT_CYCLES)),
    .done_o (wt_done)
  );

  // A setup can also arrive in the completion cycle, giving back-to-back transfers.
  always_comb begin
    state_d  = state_q;
    pready_d = 1'b0;
    accept   = 1'b0;
    commit   = 1'b0;
    wt_load  = 1'b0;
    wt_dec   = 1'b0;
    case (state_q)
      IDLE: accept = psel & ~penable;
      ACCESS: begin
        if (pready_q) begin
          commit  = psel & penable & write_q & ~err_q;
          state_d = IDLE;
          accept  = psel & ~penable;
        end else if (!(psel && penable)) begin
          state_d = IDLE;
        end else begin
          wt_dec   = 1'b1;
          pready_d = wt_done;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d  = ACCESS;
      wt_load  = 1'b1;
      pready_d = (WAIT_CYCLES == 0);
    end
  end

  // With zero wait states the completion is decided from the live bus.
  assign ld_idx = accept ? dec_live.idx : idx_q;
  assign ld_err = accept ? dec_live.err : err_q;
  assign ld_wr  = accept ? pwrite       : write_q;

  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_view
    assign view_w[i] = mem_q[i];
  end
  assign view_w[NUM_REGS-1] = wcnt_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = view_w[i];
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_idx == 32'(i)) rd_word = view_w[i];
    end
  end

  always_comb begin
    prdata_d  = prdata_q;
    pslverr_d = pready_d & ld_err;
    if (pready_d && !ld_wr) begin
      prdata_d = ld_err ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wcnt_q    <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (accept) begin
        idx_q   <= dec_live.idx;
        err_q   <= dec_live.err;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
      if (commit) begin
        wcnt_q <= wcnt_q + DATA_WIDTH'(1);
        for (int i = 0; i < NUM_REGS - 1; i++) begin
          if (idx_q == 32'(i)) mem_q[i] <= wdata_q;
        end
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized APB bench over three completers (1, 0 and 3 wait states, one 8-bit wide)
// checked against a transaction-level register-file model.
module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [31:0]  prdata0, prdata2;
  logic [7:0]   prdata1;
  logic [2:0]   pready, pslverr;
  logic [511:0] regs0, regs2;
  logic [127:0] regs1;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_reg  [3][16];
  logic [31:0] m_wcnt [3];
  logic [31:0] m_base [3] = '{32'h1000, 32'h0, 32'h1000};
  logic [31:0] m_mask [3] = '{32'hFFFF_FFFF, 32'hFF, 32'hFFFF_FFFF};
  int          m_wait [3] = '{1, 0, 3};

  always #5 clk = ~clk;

  apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
                  .BASE_ADDR(32'h1000), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready[0]),
    .pslverr(pslverr[0]), .regs_o(regs0));

  apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .NUM_REGS(16),
                  .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata1), .pready(pready[1]),
    .pslverr(pslverr[1]), .regs_o(regs1));

  apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
                  .BASE_ADDR(32'h1000), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata2), .pready(pready[2]),
    .pslverr(pslverr[2]), .regs_o(regs2));

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] get_prd(input int d);
    case (d)
      0:       return prdata0;
      1:       return {24'h0, prdata1};
      default: return prdata2;
    endcase
  endfunction

  function automatic logic [31:0] get_reg(input int d, input int i);
    case (d)
      0:       return regs0[i*32 +: 32];
      1:       return {24'h0, regs1[i*8 +: 8]};
      default: return regs2[i*32 +: 32];
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_wcnt[d] = '0;
      for (int i = 0; i < 16; i++) m_reg[d][i] = '0;
    end
  endtask

  // Register-file rules stated directly: aligned word inside the window, top word read-only.
  task automatic model_access(input int d, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, output bit err, output logic [31:0] rd);
    longint off;
    int     idx;
    off = longint'(a) - longint'(m_base[d]);
    idx = (off >= 0) ? int'(off / 4) : -1;
    err = (a % 4 != 0) || (off < 0) || (off / 4 >= 16) || (wr && idx == 15);
    rd  = '0;
    if (!err) begin
      if (wr) begin
        m_reg[d][idx] = wd & m_mask[d];
        m_wcnt[d]     = (m_wcnt[d] + 1) & m_mask[d];
      end else begin
        rd = (idx == 15) ? m_wcnt[d] : m_reg[d][idx];
      end
    end
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int i = 0; i < 16; i++) begin
      chk_eq($sformatf("%s.u%0d.w%0d", tag, d, i), get_reg(d, i),
             (i == 15) ? m_wcnt[d] : m_reg[d][i]);
    end
  endtask

  // Full transfer; leaves the bus in the completion cycle so a following xfer is back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
    bit          exp_err, done;
    logic [31:0] exp_rd;
    int          waits;
    @(posedge clk); #1;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = $urandom;
    waits = 0; done = 1'b0;
    while (!done && waits < 40) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else waits++;
    end
    model_access(d, wr, a, wd, exp_err, exp_rd);
    chk_eq({tag, ".done"}, 32'(done), 32'd1);
    chk_eq({tag, ".waits"}, 32'(waits), 32'(m_wait[d]));
    chk_eq({tag, ".pslverr"}, 32'(pslverr[d]), 32'(exp_err));
    if (!wr) chk_eq({tag, ".prdata"}, get_prd(d), exp_rd);
  endtask

  task automatic idle(input int d, input string tag);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    @(negedge clk);
    chk_eq({tag, ".pulse"}, 32'(pready[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          d, k;
    bit          wr;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("rst.pready%0d", i), 32'(pready[i]), 32'd0);
      chk_eq($sformatf("rst.pslverr%0d", i), 32'(pslverr[i]), 32'd0);
      chk_eq($sformatf("rst.prdata%0d", i), get_prd(i), 32'd0);
      check_regs(i, "rst");
    end
    rst_n = 1'b1;

    xfer(0, 1'b1, 32'h1008, 32'hDEAD_BEEF, "wr8");
    idle(0, "wr8");
    check_regs(0, "wr8");
    xfer(0, 1'b0, 32'h1008, 32'h0, "rd8");
    xfer(0, 1'b0, 32'h103C, 32'h0, "rdcnt");
    idle(0, "rdcnt");

    xfer(0, 1'b1, 32'h103C, 32'h1111_1111, "wro");
    xfer(0, 1'b1, 32'h1040, 32'h2222_2222, "wrange");
    xfer(0, 1'b1, 32'h1006, 32'h3333_3333, "wmis");
    xfer(0, 1'b1, 32'h0FFC, 32'h4444_4444, "wbelow");
    xfer(0, 1'b0, 32'h1044, 32'h0, "rderr");
    idle(0, "errs");
    check_regs(0, "errs");

    for (int i = 0; i < 4; i++) xfer(1, 1'b1, 32'(4 * i), 32'(8'hA0 + i), $sformatf("b2b%0d", i));
    idle(1, "b2b");
    check_regs(1, "b2b");

    // Abort in the first wait cycle of a write.
    @(posedge clk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1010; pwdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk_eq("abort.wait", 32'(pready[2]), 32'd0);
    psel = '0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq($sformatf("abort.c%0d", i), 32'(pready[2]), 32'd0);
    end
    check_regs(2, "abort");
    xfer(2, 1'b1, 32'h1010, 32'h1234_5678, "after_abort");
    idle(2, "after_abort");
    check_regs(2, "after_abort");

    // Access phase with no setup is ignored.
    @(posedge clk); #1;
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h1000; pwdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq($sformatf("nosetup.c%0d", i), 32'(pready[0]), 32'd0);
    end
    idle(0, "nosetup");
    check_regs(0, "nosetup");

    for (int n = 0; n < 80; n++) begin
      d  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 9));
      a  = m_base[d] + 32'(4 * $urandom_range(0, 17));
      if (k == 0) a = a + 32'($urandom_range(1, 3));
      if (k == 1) a = m_base[d] - 32'(4 * $urandom_range(1, 4));
      xfer(d, wr, a, $urandom, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) idle(d, $sformatf("rnd%0d", n));
    end
    idle(0, "rnd_end");
    for (int i = 0; i < 3; i++) check_regs(i, "rnd");

    // Reset during the wait phase of a write.
    @(posedge clk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1014; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_eq("midrst.pready", 32'(pready[2]), 32'd0);
    chk_eq("midrst.pslverr", 32'(pslverr[2]), 32'd0);
    chk_eq("midrst.prdata", get_prd(2), 32'd0);
    chk_eq("midrst.prdata0", get_prd(0), 32'd0);
    check_regs(2, "midrst");
    psel = '0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, 32'h1014, 32'h0, "midrst_rd");
    idle(2, "midrst_rd");
    check_regs(2, "midrst_rd");

    // Counter wrap on the 8-bit instance.
    for (int i = 0; i < 255; i++) xfer(1, 1'b1, 32'(4 * (i % 15)), $urandom, "fill");
    idle(1, "fill");
    chk_eq("wrap.full", get_reg(1, 15), 32'hFF);
    xfer(1, 1'b1, 32'h0, 32'h77, "wrap");
    idle(1, "wrap");
    chk_eq("wrap.zero", get_reg(1, 15), 32'h0);
    check_regs(1, "wrap");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
